lot_controller: RTL and testbench
=================================

LOT_CONTROLLER -- requirements
Module: lot_controller

Interface
REQ-001 SHALL have parameter CAPACITY, default 25; maximum number of cars in the lot; legal range 1..31.
REQ-002 SHALL have port clk, input, 1 bit; the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-004 SHALL have port sensor_a, input, 1 bit; outer photo-sensor, 1 = beam blocked; asynchronous to clk.
REQ-005 SHALL have port sensor_b, input, 1 bit; inner photo-sensor, 1 = beam blocked; asynchronous to clk.
REQ-006 SHALL have port count, output, 5 bits; current occupancy, unsigned; feeds the HEX display decoder.
REQ-007 SHALL have port full, output, 1 bit; high when count == CAPACITY.
REQ-008 SHALL have port empty, output, 1 bit; high when count == 0.
REQ-009 SHALL have port enter_pulse, output, 1 bit; one-cycle pulse on each completed entry sequence.
REQ-010 SHALL have port exit_pulse, output, 1 bit; one-cycle pulse on each completed exit sequence.

Function
REQ-011 SHALL pass sensor_a and sensor_b through a 2-flop synchronizer each; the FSM sees only synchronized values sa and sb.
REQ-012 SHALL implement FSM states IDLE, EN1, EN2, EN3, EX1, EX2, EX3; {sa,sb} is written as a 2-bit value.
REQ-013 Entry path SHALL be IDLE-10->EN1, EN1-11->EN2, EN2-01->EN3, EN3-00->IDLE; the last transition completes an entry.
REQ-014 Exit path SHALL be IDLE-01->EX1, EX1-11->EX2, EX2-10->EX3, EX3-00->IDLE; the last transition completes an exit.
REQ-015 Back-up moves SHALL be legal: EN2-10->EN1, EN3-11->EN2, EX2-01->EX1, EX3-11->EX2.
REQ-016 Input 00 in any state other than EN3/EX3 SHALL return the FSM to IDLE with no event (aborted pass).
REQ-017 Any {sa,sb} not listed for the current state SHALL hold the current state with no event.
REQ-018 From IDLE, input 11 SHALL hold IDLE.
REQ-019 On a completed entry, enter_pulse SHALL be high for exactly the one cycle after the completing edge.
REQ-020 On a completed entry, count SHALL increment on that same edge, except when count == CAPACITY, where count holds.
REQ-021 On a completed exit, exit_pulse SHALL be high for one cycle on the same timing as REQ-019.
REQ-022 On a completed exit, count SHALL decrement, except when count == 0, where count holds.
REQ-023 enter_pulse SHALL fire even when count is saturated; count SHALL never wrap below 0 or above CAPACITY.
REQ-024 enter_pulse and exit_pulse SHALL never be high in the same cycle.
REQ-025 full and empty SHALL be registered and SHALL change on the same edge as count.
REQ-026 Latency from raw sensors reaching 00 to count/pulse update SHALL be 3 clk edges: 2 synchronizer edges plus 1 FSM edge.

Reset
REQ-027 While reset is high at a clk edge, the following SHALL all be forced:
- FSM state = IDLE
- count = 0
- empty = 1
- full = 0
- enter_pulse = 0, exit_pulse = 0
- synchronizer flops = 0
REQ-028 Reset asserted mid-sequence (e.g. in EN2) SHALL discard the sequence; that car's pass SHALL NOT be counted after reset releases.
REQ-029 Reset SHALL take priority over any completing transition on the same edge.

Structure
REQ-030 Shared package lot_pkg SHALL hold:
- the FSM state enum type
- CNT_W = 5
- the default CAPACITY constant
REQ-031 The synchronizer SHALL be one sub-module, bit_sync (2-flop, 1 bit), instantiated twice.
REQ-032 FSM next-state logic and the counter SHALL live in lot_controller; count SHALL connect directly to the HEX decoder's 5-bit input in the top level.

Verification
REQ-033 Reset, then entry sequence 00,10,11,01,00 (each held 4 cycles) -> enter_pulse one cycle, count 0->1, empty 1->0.
REQ-034 From count=1, exit sequence 00,01,11,10,00 -> exit_pulse one cycle, count=0, empty=1; a second exit -> exit_pulse, count stays 0.
REQ-035 Aborted pass 10,11,10,00 -> no pulse, count unchanged; back-up pass 10,11,01,11,01,00 -> one entry counted.
REQ-036 26 consecutive entries from 0 -> count reaches 25, full=1 after the 25th; 26th gives enter_pulse with count held at 25.
REQ-037 Reset asserted while in EN3, then 00 applied after release -> count stays at its reset value 0, no pulse.
REQ-038 Raw sensor toggle shorter than 1 clk between edges (10 for 0.5 cycle) -> no FSM event; pulse latency checked as exactly 3 edges.

Source files
------------

// File: rtl/lot_pkg.sv
// Shared types and constants for the parking-lot entry/exit controller.
// The FSM step function maps (state, {sa,sb}) to the next state plus a completion event.
package lot_pkg;

  localparam int CNT_W        = 5;
  localparam int DEF_CAPACITY = 25;

  typedef enum logic [2:0] {
    IDLE,
    EN1,
    EN2,
    EN3,
    EX1,
    EX2,
    EX3
  } lot_state_e;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_ENTER,
    EV_EXIT
  } lot_event_e;

  typedef struct packed {
    lot_state_e state;
    lot_event_e ev;
  } fsm_step_t;

  function automatic fsm_step_t fsm_next(input lot_state_e cur, input logic [1:0] ab);
    fsm_step_t r;
    r.state = cur;
    r.ev    = EV_NONE;
    case (cur)
      IDLE: begin
        if (ab == 2'b10)      r.state = EN1;
        else if (ab == 2'b01) r.state = EX1;
      end
      EN1: begin
        if (ab == 2'b11)      r.state = EN2;
        else if (ab == 2'b00) r.state = IDLE;
      end
      EN2: begin
        if (ab == 2'b01)      r.state = EN3;
        else if (ab == 2'b10) r.state = EN1;
        else if (ab == 2'b00) r.state = IDLE;
      end
      EN3: begin
        if (ab == 2'b00) begin
          r.state = IDLE;
          r.ev    = EV_ENTER;
        end else if (ab == 2'b11) begin
          r.state = EN2;
        end
      end
      EX1: begin
        if (ab == 2'b11)      r.state = EX2;
        else if (ab == 2'b00) r.state = IDLE;
      end
      EX2: begin
        if (ab == 2'b10)      r.state = EX3;
        else if (ab == 2'b01) r.state = EX1;
        else if (ab == 2'b00) r.state = IDLE;
      end
      EX3: begin
        if (ab == 2'b00) begin
          r.state = IDLE;
          r.ev    = EV_EXIT;
        end else if (ab == 2'b11) begin
          r.state = EX2;
        end
      end
      default: r.state = IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for one asynchronous level input; 2 clk edges of latency.
// Clears to 0 on synchronous reset; no flow control.
module bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/lot_controller.sv
// Parking-lot occupancy counter driven by two photo-sensors; all outputs registered.
// Raw sensor change to count/pulse update takes 3 clk edges; no flow control.
module lot_controller
  import lot_pkg::*;
#(
  parameter int CAPACITY = DEF_CAPACITY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_a,
  input  logic             sensor_b,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             enter_pulse,
  output logic             exit_pulse
);

  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

  logic sa, sb;

  bit_sync u_sync_a (
    .clk  (clk),
    .reset(reset),
    .d    (sensor_a),
    .q    (sa)
  );

  bit_sync u_sync_b (
    .clk  (clk),
    .reset(reset),
    .d    (sensor_b),
    .q    (sb)
  );

  lot_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             enter_q, enter_d;
  logic             exit_q, exit_d;
  fsm_step_t        step;

  always_comb begin
    step    = fsm_next(state_q, {sa, sb});
    state_d = step.state;
    count_d = count_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    case (step.ev)
      EV_ENTER: begin
        enter_d = 1'b1;
        if (count_q != CAP_C) count_d = count_q + CNT_W'(1);
      end
      EV_EXIT: begin
        exit_d = 1'b1;
        if (count_q != '0) count_d = count_q - CNT_W'(1);
      end
      default: begin
        enter_d = 1'b0;
        exit_d  = 1'b0;
      end
    endcase
    // Flags derive from the next count so they move on the same edge as count.
    full_d  = (count_d == CAP_C);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
    end
  end

  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign enter_pulse = enter_q;
  assign exit_pulse  = exit_q;

endmodule

// File: tb/tb_lot_controller.sv
// Randomized scoreboard bench for lot_controller with a path-position reference model.
module tb_lot_controller;

  localparam int CAP = 25;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_a, sensor_b;
  logic [4:0] count;
  logic       full, empty, enter_pulse, exit_pulse;

  always #5 clk = ~clk;

  lot_controller #(.CAPACITY(CAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .sensor_a   (sensor_a),
    .sensor_b   (sensor_b),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .enter_pulse(enter_pulse),
    .exit_pulse (exit_pulse)
  );

  typedef struct {
    bit is_enter;
    int cnt;
    int due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_on = 1'b0;

  // Reference model: a pass is a walk along a 3-step pattern path; 2=10, 3=11, 1=01.
  int m_cnt = 0, m_dir = 0, m_pos = 0, cur_p = 0;
  int en_path[4] = '{0, 2, 3, 1};
  int ex_path[4] = '{0, 1, 3, 2};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int path_at(input int dir, input int pos);
    return (dir == 1) ? en_path[pos] : ex_path[pos];
  endfunction

  function automatic void model_step(input int p, input int t);
    exp_t e;
    int   nxt, prv;
    if (m_dir == 0) begin
      if (p == 2) begin m_dir = 1; m_pos = 1; end
      else if (p == 1) begin m_dir = 2; m_pos = 1; end
      return;
    end
    if (p == 0) begin
      if (m_pos == 3) begin
        e.is_enter = (m_dir == 1);
        if (m_dir == 1) m_cnt = (m_cnt < CAP) ? m_cnt + 1 : m_cnt;
        else            m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        e.cnt = m_cnt;
        e.due = t + 3;
        q.push_back(e);
      end
      m_dir = 0;
      m_pos = 0;
      return;
    end
    nxt = (m_pos < 3) ? path_at(m_dir, m_pos + 1) : -1;
    prv = (m_pos >= 2) ? path_at(m_dir, m_pos - 1) : -1;
    if (p == nxt)      m_pos = m_pos + 1;
    else if (p == prv) m_pos = m_pos - 1;
  endfunction

  // Called at posedge+1; the pattern is seen by the model at the current cycle.
  task automatic apply(input int p, input int hold);
    sensor_a = p[1];
    sensor_b = p[0];
    cur_p    = p;
    model_step(p, cyc);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_seq(input int pats[$], input int hold);
    foreach (pats[i]) apply(pats[i], hold);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected pulses still pending", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset(input int n);
    drain();
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    m_cnt = 0;
    m_dir = 0;
    m_pos = 0;
    model_step(cur_p, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on && !reset) begin
      while (q.size() > 0 && cyc > q[0].due) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse: expected enter=%0d pulse absent at cycle %0d", q[0].is_enter, q[0].due);
        void'(q.pop_front());
      end
      check("pulse_exclusive", int'(enter_pulse & exit_pulse), 0);
      check("full_flag", int'(full), int'(count == CAP));
      check("empty_flag", int'(empty), int'(count == 0));
      if (enter_pulse || exit_pulse) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: enter=%0d exit=%0d count=%0d, required none", enter_pulse, exit_pulse, count);
        end else begin
          e = q.pop_front();
          check("pulse_kind", int'(enter_pulse), int'(e.is_enter));
          check("pulse_latency", cyc, e.due);
          check("count", int'(count), e.cnt);
          check("full", int'(full), int'(e.cnt == CAP));
          check("empty", int'(empty), int'(e.cnt == 0));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, np, hold;
    int pats[$];
    reset    = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_count", int'(count), 0);
    check("reset_empty", int'(empty), 1);
    check("reset_full", int'(full), 0);
    check("reset_enter", int'(enter_pulse), 0);
    check("reset_exit", int'(exit_pulse), 0);
    reset  = 1'b0;
    mon_on = 1'b1;

    // Directed entry then two exits (second one saturates at 0).
    apply_seq('{0, 2, 3, 1, 0}, 4);
    drain();
    check("after_entry_count", int'(count), 1);
    apply_seq('{0, 1, 3, 2, 0}, 4);
    apply_seq('{0, 1, 3, 2, 0}, 4);
    drain();
    check("after_exits_count", int'(count), 0);

    // Aborted pass, then a pass with back-ups.
    apply_seq('{2, 3, 2, 0}, 4);
    apply_seq('{2, 3, 1, 3, 1, 0}, 4);
    drain();
    check("backup_count", int'(count), 1);

    // Half-cycle glitches never cross a clock edge and must be invisible.
    sensor_a = 1'b1;
    #4;
    sensor_a = 1'b0;
    @(posedge clk);
    #1;
    apply_seq('{2, 3, 1}, 4);
    sensor_b = 1'b0;
    #4;
    sensor_b = 1'b1;
    @(posedge clk);
    #1;
    apply(1, 2);
    apply(0, 4);
    drain();
    check("glitch_count", int'(count), 2);

    // Saturation at capacity.
    do_reset(2);
    for (int i = 0; i < 26; i++) apply_seq('{2, 3, 1, 0}, 2);
    drain();
    check("sat_count", int'(count), CAP);
    check("sat_full", int'(full), 1);

    // Random passes.
    for (int i = 0; i < 80; i++) begin
      k    = $urandom_range(0, 4);
      hold = $urandom_range(1, 4);
      case (k)
        0: apply_seq('{2, 3, 1, 0}, hold);
        1: apply_seq('{1, 3, 2, 0}, hold);
        2: apply_seq('{2, 3, 2, 0}, hold);
        3: apply_seq('{1, 3, 2, 3, 2, 0}, hold);
        default: begin
          pats.delete();
          np = $urandom_range(3, 7);
          for (int j = 0; j < np; j++) pats.push_back(int'($urandom_range(0, 3)));
          pats.push_back(0);
          apply_seq(pats, hold);
        end
      endcase
    end
    drain();

    // Reset while in EN3 discards the pass.
    do_reset(2);
    apply_seq('{2, 3, 1}, 4);
    do_reset(2);
    apply(0, 6);
    drain();
    check("reset_en3_count", int'(count), 0);
    check("reset_en3_empty", int'(empty), 1);

    // Reset on the exact completing edge wins.
    apply_seq('{2, 3, 1}, 4);
    drain();
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    cur_p    = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_cnt = 0;
    m_dir = 0;
    m_pos = 0;
    check("prio_enter", int'(enter_pulse), 0);
    check("prio_count", int'(count), 0);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("prio_count_later", int'(count), 0);
    drain();

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
